// File: rtl/id_ex_stage.sv
// ID/EX pipeline stage: 2-entry skid buffer between decode and the ALU.
// Operand forwarding and function-code legality are resolved once, at accept.
module id_ex_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    input  logic [31:0] imm,
    input  logic [4:0]  rs1_addr,
    input  logic [4:0]  rs2_addr,
    input  logic [4:0]  rd_addr,
    input  logic        alu_src_imm,
    input  logic [3:0]  alu_ctrl_in,
    input  logic        reg_write_in,
    input  logic        flush,
    input  logic        exmem_reg_write,
    input  logic        memwb_reg_write,
    input  logic [4:0]  exmem_rd,
    input  logic [4:0]  memwb_rd,
    input  logic [31:0] exmem_result,
    input  logic [31:0] memwb_result,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] in1,
    output logic [31:0] in2,
    output logic [3:0]  alu_ctrl,
    output logic [4:0]  rd_out,
    output logic        reg_write_out,
    output logic        ill_op
);

    typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_TWO} state_t;

    typedef struct packed {
        logic [31:0] in1;
        logic [31:0] in2;
        logic [3:0]  alu_ctrl;
        logic [4:0]  rd;
        logic        reg_write;
        logic        ill_op;
    } entry_t;

    state_t      r_state;
    logic        r_in_ready;
    logic        r_out_valid;
    entry_t      r_head;
    entry_t      r_tail;

    state_t      w_next_state;
    logic        w_accept;
    logic        w_consume;
    logic        w_load_head;
    logic        w_load_tail;
    logic        w_promote;
    logic        w_illegal;
    logic [31:0] w_rs1_fwd;
    logic [31:0] w_rs2_fwd;
    entry_t      w_new;

    assign w_accept  = in_valid && r_in_ready;
    assign w_consume = r_out_valid && out_ready;

    // EX/MEM wins over MEM/WB; x0 is hard-wired zero and never forwarded.
    always_comb begin
        w_rs1_fwd = rs1_data;
        if (exmem_reg_write && (exmem_rd == rs1_addr) && (rs1_addr != 5'd0))
            w_rs1_fwd = exmem_result;
        else if (memwb_reg_write && (memwb_rd == rs1_addr) && (rs1_addr != 5'd0))
            w_rs1_fwd = memwb_result;

        w_rs2_fwd = rs2_data;
        if (exmem_reg_write && (exmem_rd == rs2_addr) && (rs2_addr != 5'd0))
            w_rs2_fwd = exmem_result;
        else if (memwb_reg_write && (memwb_rd == rs2_addr) && (rs2_addr != 5'd0))
            w_rs2_fwd = memwb_result;
    end

    assign w_illegal       = (alu_ctrl_in > 4'd8);
    assign w_new.in1       = w_rs1_fwd;
    assign w_new.in2       = alu_src_imm ? imm : w_rs2_fwd;
    assign w_new.alu_ctrl  = w_illegal ? 4'd0 : alu_ctrl_in;
    assign w_new.rd        = rd_addr;
    assign w_new.reg_write = reg_write_in && !w_illegal;
    assign w_new.ill_op    = w_illegal;

    // NOTE: every signal written here gets a default first, so no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        w_load_head  = 1'b0;
        w_load_tail  = 1'b0;
        w_promote    = 1'b0;
        if (flush) begin
            w_next_state = ST_EMPTY;
        end else begin
            unique case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        w_next_state = ST_ONE;
                        w_load_head  = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (w_accept && w_consume) begin
                        w_load_head = 1'b1;
                    end else if (w_accept) begin
                        w_next_state = ST_TWO;
                        w_load_tail  = 1'b1;
                    end else if (w_consume) begin
                        w_next_state = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (w_consume) begin
                        w_next_state = ST_ONE;
                        w_promote    = 1'b1;
                    end
                end
                default: w_next_state = ST_EMPTY;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_EMPTY;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_head      <= '0;
        end else begin
            r_state     <= w_next_state;
            r_in_ready  <= (w_next_state != ST_TWO);
            r_out_valid <= (w_next_state != ST_EMPTY);
            if (w_load_head)
                r_head <= w_new;
            else if (w_promote)
                r_head <= r_tail;
        end
    end

    // NOTE: the tail payload has no reset; it is only ever read after being loaded.
    always_ff @(posedge clk) begin
        if (w_load_tail)
            r_tail <= w_new;
    end

    assign in_ready      = r_in_ready;
    assign out_valid     = r_out_valid;
    assign in1           = r_head.in1;
    assign in2           = r_head.in2;
    assign alu_ctrl      = r_head.alu_ctrl;
    assign rd_out        = r_head.rd;
    assign reg_write_out = r_head.reg_write;
    assign ill_op        = r_head.ill_op;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: vector table streamed through a scoreboard,
// plus hand-written backpressure, flush and reset sequences.
module tb_id_ex_stage;

    typedef struct packed {
        logic [31:0] in1;
        logic [31:0] in2;
        logic [3:0]  ctrl;
        logic [4:0]  rd;
        logic        rw;
        logic        ill;
    } exp_t;

    typedef struct {
        logic [4:0]  rs1a;
        logic [31:0] rs1d;
        logic [4:0]  rs2a;
        logic [31:0] rs2d;
        logic        src_imm;
        logic [31:0] imm;
        logic [3:0]  ctrl;
        logic [4:0]  rd;
        logic        rw;
        logic        exw;
        logic [4:0]  exrd;
        logic [31:0] exres;
        logic        mww;
        logic [4:0]  mwrd;
        logic [31:0] mwres;
        exp_t        exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] rs1_data, rs2_data, imm;
    logic [4:0]  rs1_addr, rs2_addr, rd_addr;
    logic        alu_src_imm;
    logic [3:0]  alu_ctrl_in;
    logic        reg_write_in;
    logic        flush;
    logic        exmem_reg_write, memwb_reg_write;
    logic [4:0]  exmem_rd, memwb_rd;
    logic [31:0] exmem_result, memwb_result;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] in1, in2;
    logic [3:0]  alu_ctrl;
    logic [4:0]  rd_out;
    logic        reg_write_out;
    logic        ill_op;

    int   n_tests = 0;
    int   n_fail  = 0;
    logic mon_en  = 1'b0;
    exp_t cur_exp;
    exp_t sb_q[$];
    vec_t vecs[10];

    id_ex_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr),
        .alu_src_imm(alu_src_imm), .alu_ctrl_in(alu_ctrl_in), .reg_write_in(reg_write_in),
        .flush(flush),
        .exmem_reg_write(exmem_reg_write), .memwb_reg_write(memwb_reg_write),
        .exmem_rd(exmem_rd), .memwb_rd(memwb_rd),
        .exmem_result(exmem_result), .memwb_result(memwb_result),
        .out_valid(out_valid), .out_ready(out_ready),
        .in1(in1), .in2(in2), .alu_ctrl(alu_ctrl), .rd_out(rd_out),
        .reg_write_out(reg_write_out), .ill_op(ill_op)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at time %0t, required finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [74:0] act, input logic [74:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic exp_t head_now();
        exp_t h;
        h.in1  = in1;
        h.in2  = in2;
        h.ctrl = alu_ctrl;
        h.rd   = rd_out;
        h.rw   = reg_write_out;
        h.ill  = ill_op;
        return h;
    endfunction

    function automatic vec_t mk(
        input logic [4:0] rs1a, input logic [31:0] rs1d,
        input logic [4:0] rs2a, input logic [31:0] rs2d,
        input logic src, input logic [31:0] im,
        input logic [3:0] ctrl, input logic [4:0] rd, input logic rw,
        input logic exw, input logic [4:0] exrd, input logic [31:0] exres,
        input logic mww, input logic [4:0] mwrd, input logic [31:0] mwres,
        input logic [31:0] e1, input logic [31:0] e2, input logic [3:0] ectrl,
        input logic erw, input logic eill);
        vec_t v;
        v.rs1a = rs1a; v.rs1d = rs1d; v.rs2a = rs2a; v.rs2d = rs2d;
        v.src_imm = src; v.imm = im; v.ctrl = ctrl; v.rd = rd; v.rw = rw;
        v.exw = exw; v.exrd = exrd; v.exres = exres;
        v.mww = mww; v.mwrd = mwrd; v.mwres = mwres;
        v.exp.in1 = e1; v.exp.in2 = e2; v.exp.ctrl = ectrl;
        v.exp.rd = rd; v.exp.rw = erw; v.exp.ill = eill;
        return v;
    endfunction

    task automatic apply(input vec_t v);
        rs1_addr = v.rs1a; rs1_data = v.rs1d; rs2_addr = v.rs2a; rs2_data = v.rs2d;
        alu_src_imm = v.src_imm; imm = v.imm; alu_ctrl_in = v.ctrl;
        rd_addr = v.rd; reg_write_in = v.rw;
        exmem_reg_write = v.exw; exmem_rd = v.exrd; exmem_result = v.exres;
        memwb_reg_write = v.mww; memwb_rd = v.mwrd; memwb_result = v.mwres;
        cur_exp = v.exp;
    endtask

    // Outputs sampled here reflect the edge just taken; inputs set here feed the next edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input string name);
        int budget = 20;
        while ((sb_q.size() != 0 || out_valid) && budget > 0) begin
            step();
            budget--;
        end
        check(name, 75'(sb_q.size()), 75'(0));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"},  75'(in_ready),  75'(0));
        check({tag, "_out_valid"}, 75'(out_valid), 75'(0));
        check({tag, "_payload"},   75'(head_now()), 75'(0));
    endtask

    // Scoreboard: pop/compare on consume, push on accept; flush or reset drops everything.
    always @(negedge clk) begin
        if (mon_en) begin
            if (rst || flush) begin
                sb_q.delete();
            end else begin
                if (out_valid && out_ready) begin
                    if (sb_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL sb_underflow: got consumed entry %h, expected no entry", head_now());
                    end else begin
                        check("sb_entry", 75'(head_now()), 75'(sb_q.pop_front()));
                    end
                end
                if (in_valid && in_ready)
                    sb_q.push_back(cur_exp);
            end
        end
    end

    initial begin
        vecs[0] = mk(1, 32'd5, 2, 32'd7, 0, 0, 4'b0010, 3, 1, 0, 0, 0, 0, 0, 0,
                     32'd5, 32'd7, 4'b0010, 1, 0);
        vecs[1] = mk(4, 32'h11, 5, 32'h22, 0, 0, 4'b0000, 6, 1, 1, 4, 32'hAAAA_0000, 1, 4, 32'h5555,
                     32'hAAAA_0000, 32'h22, 4'b0000, 1, 0);
        vecs[2] = mk(0, 32'h1234, 0, 32'h99, 0, 0, 4'b0011, 7, 1, 1, 0, 32'hAAAA_0000, 1, 0, 32'h5555,
                     32'h1234, 32'h99, 4'b0011, 1, 0);
        vecs[3] = mk(8, 32'h1, 9, 32'h2, 0, 0, 4'b1000, 10, 1, 1, 8, 32'hDEAD, 1, 9, 32'hCAFE,
                     32'hDEAD, 32'hCAFE, 4'b1000, 1, 0);
        vecs[4] = mk(7, 32'h70, 7, 32'h71, 0, 0, 4'b0101, 11, 0, 0, 7, 32'hBAD0, 0, 7, 32'hBAD1,
                     32'h70, 32'h71, 4'b0101, 0, 0);
        vecs[5] = mk(1, 32'h10, 3, 32'h77, 1, 32'hFFFF_FFFC, 4'b0001, 2, 1, 1, 3, 32'hBEEF, 1, 3, 32'hF00D,
                     32'h10, 32'hFFFF_FFFC, 4'b0001, 1, 0);
        vecs[6] = mk(2, 32'h20, 3, 32'h30, 0, 0, 4'b1011, 12, 1, 0, 0, 0, 0, 0, 0,
                     32'h20, 32'h30, 4'b0000, 0, 1);
        vecs[7] = mk(2, 32'h21, 3, 32'h31, 0, 0, 4'b1001, 13, 0, 0, 0, 0, 0, 0, 0,
                     32'h21, 32'h31, 4'b0000, 0, 1);
        vecs[8] = mk(2, 32'h22, 3, 32'h32, 1, 32'h5, 4'b1111, 14, 1, 0, 0, 0, 0, 0, 0,
                     32'h22, 32'h5, 4'b0000, 0, 1);
        vecs[9] = mk(6, 32'h60, 6, 32'h61, 0, 0, 4'b0100, 15, 1, 1, 5, 32'hE0, 1, 6, 32'hAB,
                     32'hAB, 32'hAB, 4'b0100, 1, 0);

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
        apply(vecs[0]);

        // Reset state.
        step();
        mon_en = 1'b1;
        step();
        check_reset_outputs("reset");
        rst = 1'b0;
        step();
        check("rst_release_in_ready", 75'(in_ready), 75'(1));
        check("rst_release_out_valid", 75'(out_valid), 75'(0));

        // Streaming pass-through of the whole table with the ALU always ready.
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            apply(vecs[i]);
            in_valid = 1'b1;
            step();
            if (i == 0)
                check("latency_out_valid", 75'(out_valid), 75'(1));
        end
        in_valid = 1'b0;
        wait_drain("stream_drain");

        // Backpressure: fill both entries, hold, then release.
        out_ready = 1'b0;
        apply(vecs[1]); in_valid = 1'b1;
        step();
        check("bp_in_ready_one", 75'(in_ready), 75'(1));
        apply(vecs[3]);
        step();
        check("bp_in_ready_two", 75'(in_ready), 75'(0));
        check("bp_head_a", 75'(head_now()), 75'(vecs[1].exp));
        apply(vecs[5]);
        exmem_reg_write = 1'b1; exmem_rd = 5'd4; exmem_result = 32'h0BAD_0BAD;
        repeat (2) step();
        check("bp_head_a_held", 75'(head_now()), 75'(vecs[1].exp));
        check("bp_still_full", 75'(in_ready), 75'(0));
        in_valid = 1'b0; out_ready = 1'b1;
        step();
        check("bp_head_b_next", 75'(head_now()), 75'(vecs[3].exp));
        check("bp_b_valid", 75'(out_valid), 75'(1));
        step();
        check("bp_empty_after", 75'(out_valid), 75'(0));
        wait_drain("bp_drain");

        // Flush while full with a new instruction presented.
        out_ready = 1'b0;
        apply(vecs[0]); in_valid = 1'b1;
        step();
        apply(vecs[2]);
        step();
        check("flush_full_before", 75'(in_ready), 75'(0));
        apply(vecs[4]); flush = 1'b1;
        step();
        check("flush_two_out_valid", 75'(out_valid), 75'(0));
        check("flush_two_in_ready", 75'(in_ready), 75'(1));

        // Flush in ONE while an accept happens: the new instruction is discarded too.
        flush = 1'b0; apply(vecs[0]);
        step();
        apply(vecs[5]); flush = 1'b1;
        step();
        check("flush_one_out_valid", 75'(out_valid), 75'(0));
        check("flush_one_in_ready", 75'(in_ready), 75'(1));
        flush = 1'b0; in_valid = 1'b0;
        step();
        check("flush_stays_empty", 75'(out_valid), 75'(0));

        // Reset while full.
        apply(vecs[0]); in_valid = 1'b1;
        step();
        apply(vecs[6]);
        step();
        apply(vecs[1]); rst = 1'b1;
        step();
        check_reset_outputs("rst_mid1");
        step();
        check_reset_outputs("rst_mid2");
        rst = 1'b0; in_valid = 1'b0;
        step();
        check("rst_mid_release_in_ready", 75'(in_ready), 75'(1));

        // Still functional after reset.
        out_ready = 1'b1;
        apply(vecs[9]); in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        wait_drain("post_reset_drain");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
